// File: rtl/train_seq_ctrl.sv
// Training-sequence controller: steps a run of N inputs through a D-block-deep
// pipeline, one cycle block (cpc clocks) per input slot, plus D drain blocks.
module train_seq_ctrl #(
   parameter int p    = 64,
   parameter int fo   = 8,
   parameter int z    = 32,
   parameter int ec   = 2,
   parameter int cpc  = p * fo / z + ec,
   parameter int L    = 3,
   parameter int maxN = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [$clog2(maxN+1)-1:0]   num_inputs,
   input  logic                        abort,
   output logic                        ready,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(cpc)-1:0]      cycle_index,
   output logic                        cycle_clk,
   output logic                        in_valid,
   output logic [$clog2(maxN)-1:0]     in_index,
   output logic                        up_en,
   output logic [1:0]                  fsm_state
);

   localparam int d  = 2 * (L - 1);
   localparam int nw = $clog2(maxN + 1);
   localparam int cw = $clog2(cpc);
   localparam int iw = $clog2(maxN);
   // Block counter must hold maxN+d-1 without wrapping.
   localparam int bw = $clog2(maxN + d + 1);

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_run  = 2'd1;
   localparam logic [1:0] st_done = 2'd2;

   logic [1:0]    state;
   logic [cw-1:0] cyc;
   logic [bw-1:0] blk;
   logic [nw-1:0] n_lat;
   logic          last_cyc;
   logic          last_blk;
   logic          running;

   assign running  = (state == st_run);
   assign last_cyc = (cyc == cw'(cpc - 1));
   assign last_blk = (blk == (bw'(n_lat) + bw'(d - 1)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= st_idle;
         cyc   <= '0;
         blk   <= '0;
         n_lat <= '0;
      end else if (abort && (state != st_idle)) begin
         state <= st_idle;
         cyc   <= '0;
         blk   <= '0;
      end else begin
         case (state)
            st_idle: begin
               // A start coinciding with abort is dropped, as is an empty run.
               if (start && !abort && (num_inputs != '0)) begin
                  n_lat <= num_inputs;
                  state <= st_run;
                  cyc   <= '0;
                  blk   <= '0;
               end
            end
            st_run: begin
               if (last_cyc) begin
                  cyc <= '0;
                  if (last_blk) begin
                     state <= st_done;
                     blk   <= '0;
                  end else begin
                     blk <= blk + bw'(1);
                  end
               end else begin
                  cyc <= cyc + cw'(1);
               end
            end
            st_done: begin
               state <= st_idle;
               cyc   <= '0;
               blk   <= '0;
            end
            default: begin
               state <= st_idle;
               cyc   <= '0;
               blk   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      ready       = (state == st_idle);
      busy        = running;
      done        = (state == st_done);
      cycle_index = running ? cyc : '0;
      cycle_clk   = running && last_cyc;
      in_valid    = running && (blk < bw'(n_lat));
      in_index    = in_valid ? blk[iw-1:0] : '0;
      // Weight updates start once the first input has crossed the pipeline.
      up_en       = running && (blk >= bw'(d)) && (cyc < cw'(cpc - ec));
      fsm_state   = state;
   end

endmodule
